histo_frame_scheduler: RTL and testbench
========================================

# histo_frame_scheduler

Frame-granular scheduler that shares one `calculate_histogram` engine between two 8-bit gray video sources. It grants the engine to one source per frame, round-robin. It forwards the granted source's sync/data stream to the engine and tags the engine's 256-bin output with source and bin index. It sits between the two camera/preprocess pipelines and the histogram engine in the KNN accelerator.

## Interface
Parameters:
- `IMG_HEIGHT`, 256: rows per frame. Must match the engine.
- `GRAY_LEVEL`, 256: bins per histogram (≤256).

Ports:
- `clk`  in  1  single clock. Reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `src_en`  in  2  per-source enable. Bit i enables source i.
- `s0_vsync`, `s0_hsync`, `s0_data_vld`  in  1 each  source 0 sync and valid.
- `s0_data`  in  8  source 0 pixel.
- `s1_vsync`, `s1_hsync`, `s1_data_vld`  in  1 each  source 1 sync and valid.
- `s1_data`  in  8  source 1 pixel.
- `eng_vsync`, `eng_hsync`, `eng_data_vld`  out  1 each  forwarded to engine `pi_*`.
- `eng_data`  out  8  forwarded pixel.
- `eng_histo_vld`  in  1  engine `po_histo_vld`.
- `eng_histo_data`  in  32  engine `po_histo_data`.
- `grant`  out  2  one-hot owner of the engine. 0 when idle.
- `po_histo_vld`  out  1  tagged bin valid.
- `po_histo_data`  out  32  bin count.
- `po_histo_bin`  out  8  bin index, 0..GRAY_LEVEL-1.
- `po_histo_src`  out  1  source the bin belongs to.
- `frame_done`  out  1  one-cycle pulse after the last bin.
- `frame_done_src`  out  1  source of the finished frame. Valid with `frame_done`.
- `drop_cnt0`, `drop_cnt1`  out  16 each  dropped-frame counters (see Configuration).

## Operation
- Edge detection: each `sX_vsync` is registered. rise = vsync & ~vsync_d. Falling edge of the granted source's `data_vld` marks end of a row.
- Round-robin pointer `rr` resets to 0.
- States:
  - IDLE → STREAM: on a rise of an enabled source. If both rise in the same cycle, the source equal to `rr` wins. That cycle sets `grant` and latches `owner`.
  - STREAM → DRAIN: after IMG_HEIGHT row ends on `owner`.
  - DRAIN → IDLE: after GRAY_LEVEL engine words have been forwarded. On that transition, `frame_done` pulses, `frame_done_src` = owner, `rr` = ~owner, `grant` → 0.
- Forwarding:
  - While `grant` != 0 (STREAM and DRAIN), the `eng_*` outputs register the owner's four inputs.
  - Otherwise all `eng_*` outputs are 0. This guarantees the engine sees a clean vsync rise one cycle after the grant.
- Output tagging:
  - In DRAIN, each `eng_histo_vld` cycle produces one registered output word:
    - `po_histo_data` = `eng_histo_data`
    - `po_histo_bin` = bin counter; the counter increments after each word and clears on DRAIN exit
    - `po_histo_src` = owner
  - `eng_histo_vld` is ignored in IDLE and STREAM.
- Non-owner activity is discarded entirely. A further vsync rise from the owner during STREAM or DRAIN is ignored; the engine is mid-frame.
- Clearing `src_en` bit of the owner mid-frame does not abort: the frame completes. Enable is only sampled for new grants.
- Widths: row counter is clog2(IMG_HEIGHT+1) bits. Bin counter is 9 bits internally, truncated to 8 for output.
- Reset mid-operation: all state returns to IDLE. Counters and `rr` clear. The engine is assumed to be reset by the same `rst`.

## Timing
- Reset values: all outputs 0, including `grant`, `eng_*`, `po_*`, `frame_done`, `frame_done_src` and `drop_cnt*`.
- Source to `eng_*` latency: 1 cycle.
- Engine word to `po_histo_*` latency: 1 cycle.
- `frame_done` is asserted in the cycle after the last `po_histo_vld`.
- Grant turnaround: a rise that arrives in the same cycle `frame_done` pulses is not granted. The next grant needs a new rise (minimum 1 idle cycle).
- Sources must allow ≥ GRAY_LEVEL+2 cycles between vsync rise and first valid pixel, which covers the engine's clear phase. This is not checked.

## Configuration
- `HISTO_SCHED_DROP_CNT_EN` defined:
  - `drop_cntX` increments on every rise of enabled source X that is not granted that cycle. This covers a busy engine or a lost tie.
  - Counters saturate at 0xFFFF and clear only on `rst`.
- Not defined: `drop_cnt0` and `drop_cnt1` are constant 0 and no counter logic is built.

## Test plan
Benches run with IMG_HEIGHT=4, GRAY_LEVEL=256.
- Single source: `src_en`=01, one 4-row frame on s0 → `grant`=01 in the rise cycle, `eng_vsync` high 1 cycle later, 256 words with `po_histo_bin` 0..255 and `po_histo_src`=0, then `frame_done`=1 with `frame_done_src`=0, `grant`=00.
- Tie: both vsync rise in the same cycle after reset → s0 granted. With `_EN`, `drop_cnt1`=1. Next simultaneous rise after done → s1 granted.
- Busy drop: s1 raises vsync 3 times during an s0 frame → `eng_*` never reflects s1. With `_EN`, `drop_cnt1`=3; without it, `drop_cnt1`=0.
- Disable mid-frame: clear `src_en[0]` after row 2 of an s0 frame → the frame completes with all 256 bins and `frame_done`. A subsequent s0 rise is not granted.
- Reset mid-DRAIN: assert `rst` after bin 100 → next cycle all outputs are 0 and `grant`=00. The next s1 rise is granted with `po_histo_bin` restarting at 0.
- Stray engine words: drive `eng_histo_vld` in IDLE → `po_histo_vld` stays 0.

Source files
------------

// File: rtl/histo_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : histo_frame_scheduler
// Purpose  : Frame-granular round-robin arbiter sharing one histogram engine
//            between two gray video sources; tags engine bins with src/index.
//            Optional dropped-frame counters: define HISTO_SCHED_DROP_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module histo_frame_scheduler #(
  parameter int IMG_HEIGHT = 256,
  parameter int GRAY_LEVEL = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  src_en,
  input  logic        s0_vsync,
  input  logic        s0_hsync,
  input  logic        s0_data_vld,
  input  logic [7:0]  s0_data,
  input  logic        s1_vsync,
  input  logic        s1_hsync,
  input  logic        s1_data_vld,
  input  logic [7:0]  s1_data,
  output logic        eng_vsync,
  output logic        eng_hsync,
  output logic        eng_data_vld,
  output logic [7:0]  eng_data,
  input  logic        eng_histo_vld,
  input  logic [31:0] eng_histo_data,
  output logic [1:0]  grant,
  output logic        po_histo_vld,
  output logic [31:0] po_histo_data,
  output logic [7:0]  po_histo_bin,
  output logic        po_histo_src,
  output logic        frame_done,
  output logic        frame_done_src,
  output logic [15:0] drop_cnt0,
  output logic [15:0] drop_cnt1
);

  localparam int ROW_W = $clog2(IMG_HEIGHT + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_vs0_d, r_vs1_d, r_vld0_d, r_vld1_d;
  logic             r_owner, r_rr;
  logic [ROW_W-1:0] r_rows;
  logic [8:0]       r_bin;
  logic             w_rise0, w_rise1, w_req0, w_req1, w_pick1, w_new_grant;
  logic             w_owner, w_active, w_row_end, w_last_row, w_drain_done, w_take;
  logic [1:0]       w_grant;

  assign w_rise0 = s0_vsync & ~r_vs0_d;
  assign w_rise1 = s1_vsync & ~r_vs1_d;

  // Grants are blocked during the frame_done cycle so a fresh rise is required.
  assign w_req0      = w_rise0 & src_en[0] & (r_state == ST_IDLE) & ~frame_done;
  assign w_req1      = w_rise1 & src_en[1] & (r_state == ST_IDLE) & ~frame_done;
  assign w_pick1     = w_req1 & (~w_req0 | r_rr);
  assign w_new_grant = w_req0 | w_req1;

  assign w_owner      = (r_state == ST_IDLE) ? w_pick1 : r_owner;
  assign w_active     = ((r_state != ST_IDLE) | w_new_grant) & ~rst;
  assign w_grant      = w_active ? (w_owner ? 2'b10 : 2'b01) : 2'b00;
  assign grant        = w_grant;
  assign w_row_end    = w_owner ? (r_vld1_d & ~s1_data_vld) : (r_vld0_d & ~s0_data_vld);
  assign w_last_row   = (r_rows == ROW_W'(IMG_HEIGHT - 1));
  assign w_drain_done = (r_bin == 9'(GRAY_LEVEL));
  assign w_take       = (r_state == ST_DRAIN) & eng_histo_vld & ~w_drain_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_new_grant) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_row_end && w_last_row) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_drain_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs0_d        <= 1'b0;
      r_vs1_d        <= 1'b0;
      r_vld0_d       <= 1'b0;
      r_vld1_d       <= 1'b0;
      r_owner        <= 1'b0;
      r_rr           <= 1'b0;
      r_rows         <= '0;
      r_bin          <= '0;
      eng_vsync      <= 1'b0;
      eng_hsync      <= 1'b0;
      eng_data_vld   <= 1'b0;
      eng_data       <= '0;
      po_histo_vld   <= 1'b0;
      po_histo_data  <= '0;
      po_histo_bin   <= '0;
      po_histo_src   <= 1'b0;
      frame_done     <= 1'b0;
      frame_done_src <= 1'b0;
    end else begin
      r_vs0_d  <= s0_vsync;
      r_vs1_d  <= s1_vsync;
      r_vld0_d <= s0_data_vld;
      r_vld1_d <= s1_data_vld;
      if (r_state == ST_IDLE && w_new_grant) r_owner <= w_pick1;
      if (r_state == ST_STREAM && w_row_end)
        r_rows <= w_last_row ? '0 : r_rows + ROW_W'(1);
      if (w_active) begin
        eng_vsync    <= w_owner ? s1_vsync    : s0_vsync;
        eng_hsync    <= w_owner ? s1_hsync    : s0_hsync;
        eng_data_vld <= w_owner ? s1_data_vld : s0_data_vld;
        eng_data     <= w_owner ? s1_data     : s0_data;
      end else begin
        eng_vsync    <= 1'b0;
        eng_hsync    <= 1'b0;
        eng_data_vld <= 1'b0;
        eng_data     <= '0;
      end
      po_histo_vld <= w_take;
      if (w_take) begin
        po_histo_data <= eng_histo_data;
        po_histo_bin  <= r_bin[7:0];
        po_histo_src  <= r_owner;
        r_bin         <= r_bin + 9'd1;
      end
      frame_done <= (r_state == ST_DRAIN) & w_drain_done;
      if (r_state == ST_DRAIN && w_drain_done) begin
        frame_done_src <= r_owner;
        r_rr           <= ~r_owner;
        r_bin          <= '0;
      end
    end
  end

`ifdef HISTO_SCHED_DROP_CNT_EN
  logic [15:0] r_drop0, r_drop1;
  logic        w_drop0, w_drop1;

  // A rise of an enabled source that does not win the engine this cycle is a lost frame.
  assign w_drop0 = w_rise0 & src_en[0] & ~w_grant[0];
  assign w_drop1 = w_rise1 & src_en[1] & ~w_grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop0 <= '0;
      r_drop1 <= '0;
    end else begin
      if (w_drop0 && r_drop0 != 16'hFFFF) r_drop0 <= r_drop0 + 16'd1;
      if (w_drop1 && r_drop1 != 16'hFFFF) r_drop1 <= r_drop1 + 16'd1;
    end
  end

  assign drop_cnt0 = r_drop0;
  assign drop_cnt1 = r_drop1;
`else
  assign drop_cnt0 = 16'd0;
  assign drop_cnt1 = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_histo_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_histo_frame_scheduler
// Purpose  : Self-checking bench: vector table, directed frames, random frames
//            against a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_histo_frame_scheduler;
  localparam int IMG_HEIGHT = 4;
  localparam int GRAY_LEVEL = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  src_en = 2'b00;
  logic [1:0]  vs = 2'b00, hs = 2'b00, dv = 2'b00;
  logic [7:0]  px0 = 8'd0, px1 = 8'd0;
  logic        ehv = 1'b0;
  logic [31:0] ehd = 32'd0;

  logic        eng_vsync, eng_hsync, eng_data_vld;
  logic [7:0]  eng_data;
  logic [1:0]  grant;
  logic        po_histo_vld, po_histo_src, frame_done, frame_done_src;
  logic [31:0] po_histo_data;
  logic [7:0]  po_histo_bin;
  logic [15:0] drop_cnt0, drop_cnt1;

  histo_frame_scheduler #(.IMG_HEIGHT(IMG_HEIGHT), .GRAY_LEVEL(GRAY_LEVEL)) dut (
    .clk(clk), .rst(rst), .src_en(src_en),
    .s0_vsync(vs[0]), .s0_hsync(hs[0]), .s0_data_vld(dv[0]), .s0_data(px0),
    .s1_vsync(vs[1]), .s1_hsync(hs[1]), .s1_data_vld(dv[1]), .s1_data(px1),
    .eng_vsync(eng_vsync), .eng_hsync(eng_hsync), .eng_data_vld(eng_data_vld), .eng_data(eng_data),
    .eng_histo_vld(ehv), .eng_histo_data(ehd), .grant(grant),
    .po_histo_vld(po_histo_vld), .po_histo_data(po_histo_data), .po_histo_bin(po_histo_bin),
    .po_histo_src(po_histo_src), .frame_done(frame_done), .frame_done_src(frame_done_src),
    .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic [1:0] pvs = 2'b00;
  int   edrop [2];
  logic m_rr = 1'b0;

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  vs;
    logic        hv;
    logic [31:0] hd;
    logic [1:0]  eg;
    logic        epo;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // One clock: check the grant for the current inputs, account drops, then check forwarding.
  task automatic step(input logic [1:0] eg);
    logic [10:0] ee;
    #1;
    chk("grant", {30'd0, grant}, {30'd0, eg});
    for (int x = 0; x < 2; x++)
      if (vs[x] && !pvs[x] && src_en[x] && !eg[x] && edrop[x] < 65535) edrop[x]++;
    pvs = vs;
    ee = eg[0] ? {vs[0], hs[0], dv[0], px0} : (eg[1] ? {vs[1], hs[1], dv[1], px1} : 11'd0);
    @(posedge clk);
    #1;
    chk("eng_fwd", {21'd0, eng_vsync, eng_hsync, eng_data_vld, eng_data}, {21'd0, ee});
  endtask

  task automatic chk_drop();
`ifdef HISTO_SCHED_DROP_CNT_EN
    chk("drop_cnt0", {16'd0, drop_cnt0}, edrop[0]);
    chk("drop_cnt1", {16'd0, drop_cnt1}, edrop[1]);
`else
    chk("drop_cnt0", {16'd0, drop_cnt0}, 32'd0);
    chk("drop_cnt1", {16'd0, drop_cnt1}, 32'd0);
`endif
  endtask

  task automatic noise(input int oth);
    vs[oth] = ($urandom % 4 == 0);
    hs[oth] = 1'($urandom);
    dv[oth] = 1'($urandom);
    if (oth == 0) px0 = 8'($urandom); else px1 = 8'($urandom);
  endtask

  task automatic chk_all_zero();
    chk("rst_po_vld", {31'd0, po_histo_vld}, 32'd0);
    chk("rst_po_data", po_histo_data, 32'd0);
    chk("rst_po_bin", {24'd0, po_histo_bin}, 32'd0);
    chk("rst_po_src", {31'd0, po_histo_src}, 32'd0);
    chk("rst_done", {30'd0, frame_done, frame_done_src}, 32'd0);
    chk("rst_drop", {drop_cnt1, drop_cnt0}, 32'd0);
  endtask

  task automatic frame(input logic r0, input logic r1, input bit nz, input bit dis,
                       input bit turn, input int abort_bin);
    logic       rq0, rq1;
    int         o, oth, w, g, x;
    logic [1:0] eg;
    logic [31:0] d;
    rq0 = r0 & src_en[0];
    rq1 = r1 & src_en[1];
    if (rq0 && rq1) o = int'(m_rr); else o = rq0 ? 0 : 1;
    oth = 1 - o;
    eg  = (o == 0) ? 2'b01 : 2'b10;
    hs = 2'b00; dv = 2'b00; ehv = 1'b0;
    vs = {r1, r0};
    step(eg);
    chk("po_vld_rise", {31'd0, po_histo_vld}, 32'd0);
    step(eg);
    vs = 2'b00;
    step(eg);
    for (int r = 0; r < IMG_HEIGHT; r++) begin
      if (dis && r == 2) src_en[o] = 1'b0;
      w = $urandom_range(2, 5);
      for (int p = 0; p < w; p++) begin
        hs[o] = 1'b1; dv[o] = 1'b1;
        if (o == 0) px0 = 8'($urandom); else px1 = 8'($urandom);
        if (nz) noise(oth);
        ehv = 1'($urandom); ehd = $urandom;
        step(eg);
        chk("po_vld_stream", {31'd0, po_histo_vld}, 32'd0);
      end
      ehv = 1'b0;
      g = $urandom_range(1, 3);
      for (int p = 0; p < g; p++) begin
        hs[o] = 1'b0; dv[o] = 1'b0;
        if (nz) noise(oth);
        step(eg);
      end
    end
    for (int b = 0; b < GRAY_LEVEL; b++) begin
      if ($urandom % 2 == 1) begin
        ehv = 1'b0;
        if (nz) noise(oth);
        step(eg);
        chk("po_vld_gap", {31'd0, po_histo_vld}, 32'd0);
      end
      ehv = 1'b1; ehd = $urandom; d = ehd;
      if (nz) noise(oth);
      step(eg);
      chk("po_vld", {31'd0, po_histo_vld}, 32'd1);
      chk("po_data", po_histo_data, d);
      chk("po_bin", {24'd0, po_histo_bin}, {24'd0, 8'(b)});
      chk("po_src", {31'd0, po_histo_src}, o);
      if (b == abort_bin) begin
        rst = 1'b1; vs = 2'b00; hs = 2'b00; dv = 2'b00; ehv = 1'b0;
        step(2'b00);
        chk_all_zero();
        rst = 1'b0; m_rr = 1'b0; edrop[0] = 0; edrop[1] = 0;
        step(2'b00);
        return;
      end
    end
    ehv = 1'b0; vs = 2'b00; hs = 2'b00; dv = 2'b00;
    step(eg);
    chk("done_pulse", {31'd0, frame_done}, 32'd1);
    chk("done_src", {31'd0, frame_done_src}, o);
    chk("po_vld_after", {31'd0, po_histo_vld}, 32'd0);
    x = src_en[oth] ? oth : o;
    if (turn && src_en[x]) begin
      vs[x] = 1'b1;
      step(2'b00);
      vs = 2'b00;
    end
    step(2'b00);
    chk("done_clear", {31'd0, frame_done}, 32'd0);
    m_rr = (o == 0);
    chk_drop();
  endtask

  vec_t vt [7];

  initial begin
    logic r0, r1;
    edrop[0] = 0; edrop[1] = 0;
    vt[0] = '{en: 2'b00, vs: 2'b11, hv: 1'b0, hd: 32'd0, eg: 2'b00, epo: 1'b0};
    vt[1] = '{en: 2'b00, vs: 2'b00, hv: 1'b1, hd: 32'd5, eg: 2'b00, epo: 1'b0};
    vt[2] = '{en: 2'b01, vs: 2'b10, hv: 1'b0, hd: 32'd0, eg: 2'b00, epo: 1'b0};
    vt[3] = '{en: 2'b01, vs: 2'b00, hv: 1'b1, hd: 32'd7, eg: 2'b00, epo: 1'b0};
    vt[4] = '{en: 2'b10, vs: 2'b01, hv: 1'b0, hd: 32'd0, eg: 2'b00, epo: 1'b0};
    vt[5] = '{en: 2'b10, vs: 2'b00, hv: 1'b1, hd: 32'd3, eg: 2'b00, epo: 1'b0};
    vt[6] = '{en: 2'b11, vs: 2'b00, hv: 1'b1, hd: 32'd9, eg: 2'b00, epo: 1'b0};

    step(2'b00);
    step(2'b00);
    chk_all_zero();
    rst = 1'b0;
    step(2'b00);

    for (int i = 0; i < 7; i++) begin
      src_en = vt[i].en; vs = vt[i].vs; ehv = vt[i].hv; ehd = vt[i].hd;
      step(vt[i].eg);
      chk("vec_po_vld", {31'd0, po_histo_vld}, {31'd0, vt[i].epo});
      chk("vec_done", {31'd0, frame_done}, 32'd0);
    end
    ehv = 1'b0;
    chk_drop();

    src_en = 2'b11;
    frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);

    src_en = 2'b01;
    frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    vs[0] = 1'b1;
    step(2'b00);
    vs = 2'b00;
    step(2'b00);
    chk_drop();

    for (int i = 0; i < 5; i++) begin
      src_en = 2'($urandom_range(1, 3));
      do begin
        r0 = 1'($urandom); r1 = 1'($urandom);
      end while (!((r0 & src_en[0]) | (r1 & src_en[1])));
      frame(r0, r1, 1'b1, 1'b0, 1'($urandom), -1);
    end

    src_en = 2'b11;
    frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 100);
    src_en = 2'b10;
    frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
